uart_mm_slave: RTL and testbench

UART_MM_SLAVE -- requirements
Module: uart_mm_slave

---
 rtl/uart_mm_pkg.sv | 27 ++
 rtl/uart_mm_slave_rx_core.sv | 79 +++++++
 rtl/uart_mm_slave.sv | 146 ++++++++++++++
 tb/tb_uart_mm_slave.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/uart_mm_pkg.sv
// rtl/uart_mm_pkg.sv - register word indices, FSM encodings and frame constants shared by the UART slave
package uart_mm_pkg;

  localparam logic [3:0] REG_TX_DATA   = 4'd0;
  localparam logic [3:0] REG_TX_CTRL   = 4'd1;
  localparam logic [3:0] REG_RX_DATA   = 4'd2;
  localparam logic [3:0] REG_RX_STATUS = 4'd3;

  localparam int FRAME_BITS = 8;
  localparam logic [2:0] BIT_LAST_IDX = 3'(FRAME_BITS - 1);

  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_START = 2'd1;
  localparam logic [1:0] TX_DATA  = 2'd2;
  localparam logic [1:0] TX_STOP  = 2'd3;

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  typedef struct packed {
    logic [7:0] data;
    logic       stop_bit;
  } rx_frame_t;

endpackage

// File: rtl/uart_mm_slave_rx_core.sv
// rtl/uart_mm_slave_rx_core.sv - UART receiver: two-flop synchronizer, start-bit qualification, LSB-first shifter
module uart_rx_core
  import uart_mm_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      rx,
  output logic      done,
  output rx_frame_t frame
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  logic [1:0]    sync;
  logic          rx_s;
  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  assign rx_s = sync[1];

  // Completion is flagged in the same cycle the stop bit is sampled.
  assign done           = (state == RX_STOP) && (cnt == BIT_LAST);
  assign frame.data     = shreg;
  assign frame.stop_bit = rx_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync    <= 2'b11;
      state   <= RX_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      sync <= {sync[0], rx};
      case (state)
        RX_IDLE: begin
          cnt <= '0;
          if (!rx_s) state <= RX_START;
        end
        RX_START: begin
          // Re-check the line at mid start bit so short glitches are dropped.
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_s ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            shreg <= {rx_s, shreg[7:1]};
            if (bit_idx == BIT_LAST_IDX) state <= RX_STOP;
            else bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            state <= RX_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_mm_slave.sv
// rtl/uart_mm_slave.sv - memory-mapped UART slave: register file, transmitter, receiver instance
module uart_mm_slave
  import uart_mm_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] map_Data,
  input  logic [DATA_WIDTH-1:0] map_Address,
  input  logic                  WSel,
  input  logic                  HSel,
  output logic [DATA_WIDTH-1:0] HRData,
  output logic                  uart_tx,
  input  logic                  uart_rx
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

  logic [3:0]    idx;
  logic          wr_tx_data, wr_tx_ctrl, wr_rx_status;
  logic [7:0]    tx_data;
  logic [1:0]    tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_shreg;
  logic          tx_last;
  logic          busy;
  logic [7:0]    rx_data;
  logic          rx_valid, frame_err, overrun;
  logic          rx_done;
  rx_frame_t     rx_frame;
  logic          unused_bits;

  assign idx          = map_Address[3:0];
  assign wr_tx_data   = WSel && (idx == REG_TX_DATA);
  assign wr_tx_ctrl   = WSel && (idx == REG_TX_CTRL);
  assign wr_rx_status = WSel && (idx == REG_RX_STATUS);
  assign unused_bits  = ^{map_Address[DATA_WIDTH-1:4], map_Data[DATA_WIDTH-1:8]};

  assign busy    = (tx_state != TX_IDLE);
  assign tx_last = (tx_cnt == BIT_LAST);

  always_comb begin
    HRData = '0;
    if (HSel) begin
      case (idx)
        REG_TX_DATA:   HRData[7:0] = tx_data;
        REG_TX_CTRL:   HRData[0]   = busy;
        REG_RX_DATA:   HRData[7:0] = rx_data;
        REG_RX_STATUS: HRData[2:0] = {overrun, frame_err, rx_valid};
        default:       HRData      = '0;
      endcase
    end
  end

  always_comb begin
    case (tx_state)
      TX_START: uart_tx = 1'b0;
      TX_DATA:  uart_tx = tx_shreg[0];
      default:  uart_tx = 1'b1;
    endcase
  end

  // tx_data stays writable mid-frame; the frame works from its own shift copy.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_data  <= '0;
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shreg <= '0;
    end else begin
      if (wr_tx_data) tx_data <= map_Data[7:0];
      case (tx_state)
        TX_IDLE: begin
          if (wr_tx_ctrl && map_Data[0]) begin
            tx_shreg <= tx_data;
            tx_cnt   <= '0;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (tx_last) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_state <= TX_DATA;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (tx_last) begin
            tx_cnt   <= '0;
            tx_shreg <= {1'b0, tx_shreg[7:1]};
            if (tx_bit == BIT_LAST_IDX) tx_state <= TX_STOP;
            else tx_bit <= tx_bit + 1'b1;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_STOP: begin
          if (tx_last) begin
            tx_cnt   <= '0;
            tx_state <= TX_IDLE;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  uart_rx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk  (clk),
    .rst  (rst),
    .rx   (uart_rx),
    .done (rx_done),
    .frame(rx_frame)
  );

  // A completing frame outranks a status clear landing in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else if (rx_done) begin
      rx_data   <= rx_frame.data;
      rx_valid  <= 1'b1;
      frame_err <= ~rx_frame.stop_bit;
      overrun   <= wr_rx_status ? 1'b0 : (overrun | rx_valid);
    end else if (wr_rx_status) begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_mm_slave.sv
// tb/tb_uart_mm_slave.sv - directed-vector bench for uart_mm_slave at four clocks per bit
module tb_uart_mm_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] map_Data, map_Address;
  logic        WSel, HSel;
  logic [31:0] HRData;
  logic        uart_tx;
  logic        rx_drv;
  logic        loop;
  logic        rx_line;

  int vec_cnt = 0;
  int err_cnt = 0;
  int busy_cycles = 0;
  int frames = 0;
  logic busy_prev = 1'b0;

  assign rx_line = loop ? uart_tx : rx_drv;

  uart_mm_slave #(.DATA_WIDTH(32), .CLKS_PER_BIT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .map_Data   (map_Data),
    .map_Address(map_Address),
    .WSel       (WSel),
    .HSel       (HSel),
    .HRData     (HRData),
    .uart_tx    (uart_tx),
    .uart_rx    (rx_line)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (dut.busy) busy_cycles <= busy_cycles + 1;
    if (dut.busy && !busy_prev) frames <= frames + 1;
    busy_prev <= dut.busy;
  end

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    WSel = 1'b1; map_Address = addr; map_Data = data;
    @(negedge clk);
    WSel = 1'b0;
  endtask

  task automatic rd_expect(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    HSel = 1'b1; map_Address = addr;
    #1;
    expect_eq(tag, HRData, exp);
    HSel = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rx_drv = bits[i];
      repeat (3) @(negedge clk);
    end
    @(negedge clk);
    rx_drv = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (dut.busy && n < bound) begin
      @(negedge clk);
      n++;
    end
    expect_eq("tx_idle_in_time", {31'b0, dut.busy}, 32'h0);
  endtask

  initial begin
    logic [9:0] pat;
    int b0, f0;
    rst = 1'b1; WSel = 1'b0; HSel = 1'b0; map_Data = '0; map_Address = '0;
    rx_drv = 1'b1; loop = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    expect_eq("rst_uart_tx", {31'b0, uart_tx}, 32'h1);
    rd_expect("rst_tx_data", 32'd0, 32'h0);
    rd_expect("rst_tx_ctrl", 32'd1, 32'h0);
    rd_expect("rst_rx_data", 32'd2, 32'h0);
    rd_expect("rst_rx_status", 32'd3, 32'h0);
    #1 expect_eq("hsel_low_zero", HRData, 32'h0);

    // Single A5 frame, each bit held four clocks
    b0 = busy_cycles; f0 = frames;
    wr(32'd0, 32'hFFFF_FFA5);
    rd_expect("tx_data_a5", 32'd0, 32'hA5);
    rd_expect("unmapped_idx5", 32'd5, 32'h0);
    pat = {1'b1, 8'hA5, 1'b0};
    wr(32'd1, 32'h1);
    for (int k = 0; k < 40; k++) begin
      expect_eq($sformatf("tx_bit%0d_cyc%0d", k / 4, k % 4), {31'b0, uart_tx}, {31'b0, pat[k / 4]});
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    expect_eq("a5_busy_cycles", busy_cycles - b0, 40);
    expect_eq("a5_frames", frames - f0, 1);
    expect_eq("a5_idle_line", {31'b0, uart_tx}, 32'h1);

    // Start request while busy is ignored; TX_DATA still writable
    b0 = busy_cycles; f0 = frames;
    wr(32'd1, 32'h1);
    repeat (8) @(negedge clk);
    wr(32'd1, 32'h1);
    wr(32'd0, 32'h3C);
    rd_expect("tx_data_busy_write", 32'd0, 32'h3C);
    rd_expect("tx_ctrl_busy", 32'd1, 32'h1);
    wait_idle(100);
    repeat (20) @(negedge clk);
    expect_eq("retrig_busy_cycles", busy_cycles - b0, 40);
    expect_eq("retrig_frames", frames - f0, 1);

    // Receive path, overrun, framing error, clear
    send_byte(8'h3C, 1'b1);
    rd_expect("rx_data_3c", 32'd2, 32'h3C);
    rd_expect("rx_status_3c", 32'd3, 32'h1);
    rd_expect("rx_data_reread", 32'd2, 32'h3C);
    send_byte(8'h55, 1'b1);
    rd_expect("rx_data_55", 32'd2, 32'h55);
    rd_expect("rx_status_overrun", 32'd3, 32'h5);
    wr(32'd3, 32'h0);
    rd_expect("rx_status_clr1", 32'd3, 32'h0);

    @(negedge clk);
    rx_drv = 1'b0;
    @(negedge clk);
    rx_drv = 1'b1;
    repeat (12) @(negedge clk);
    rd_expect("glitch_status", 32'd3, 32'h0);
    rd_expect("glitch_rx_data", 32'd2, 32'h55);

    send_byte(8'h81, 1'b0);
    rd_expect("rx_data_81", 32'd2, 32'h81);
    rd_expect("rx_status_ferr", 32'd3, 32'h3);
    wr(32'd3, 32'h0);
    rd_expect("rx_status_clr2", 32'd3, 32'h0);

    // Reset during DATA, then a discarded write under reset
    wr(32'd0, 32'h11);
    wr(32'd1, 32'h1);
    repeat (8) @(negedge clk);
    expect_eq("pre_rst_busy", {31'b0, dut.busy}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    expect_eq("rst_mid_uart_tx", {31'b0, uart_tx}, 32'h1);
    expect_eq("rst_mid_busy", {31'b0, dut.busy}, 32'h0);
    wr(32'd0, 32'h99);
    rst = 1'b0;
    @(negedge clk);
    rd_expect("rst_write_discard", 32'd0, 32'h0);
    rd_expect("rst_clears_rx_data", 32'd2, 32'h0);
    expect_eq("post_rst_idle", {31'b0, uart_tx}, 32'h1);

    // Loopback of 7E
    loop = 1'b1;
    wr(32'd0, 32'h7E);
    wr(32'd1, 32'h1);
    wait_idle(100);
    repeat (10) @(negedge clk);
    rd_expect("loop_rx_data", 32'd2, 32'h7E);
    rd_expect("loop_rx_status", 32'd3, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
